// File: rtl/pixel_cluster_frame_tracker.sv
// pixel_cluster_frame_tracker
// Groups a stream of filtered pixel coordinates into up to N_CLUSTERS
// clusters per frame. Each slot remembers the anchor (its first pixel) and
// accumulates pixel count, coordinate sums and a bounding box. At end of
// frame the post-update working state is copied into a published result
// bank that stays stable until the next end of frame.
//
// Pipeline: stage 1 registers the incoming pixel, stage 2 folds it into the
// working state (and the result bank, on eof). Pixels may arrive every cycle.

module pixel_cluster_frame_tracker #(
  parameter int N_CLUSTERS   = 4,
  parameter int X_Y_BITS     = 16,
  parameter int COUNTER_BITS = 16,
  parameter int SUM_BITS     = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [X_Y_BITS-1:0]              X,
  input  logic [X_Y_BITS-1:0]              Y,
  input  logic                             valid,
  input  logic                             sof,
  input  logic                             eof,
  input  logic [X_Y_BITS-1:0]              range,
  output logic [COUNTER_BITS*N_CLUSTERS-1:0] res_count,
  output logic [SUM_BITS*N_CLUSTERS-1:0]     res_sum_x,
  output logic [SUM_BITS*N_CLUSTERS-1:0]     res_sum_y,
  output logic [X_Y_BITS*N_CLUSTERS-1:0]     res_min_x,
  output logic [X_Y_BITS*N_CLUSTERS-1:0]     res_max_x,
  output logic [X_Y_BITS*N_CLUSTERS-1:0]     res_min_y,
  output logic [X_Y_BITS*N_CLUSTERS-1:0]     res_max_y,
  output logic [COUNTER_BITS-1:0]            res_dropped,
  output logic                               res_valid,
  output logic [COUNTER_BITS-1:0]            frame_count
);

  localparam int CW = COUNTER_BITS;
  localparam int SW = SUM_BITS;
  localparam int XW = X_Y_BITS;

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // Distance without wrap: always the larger value minus the smaller one.
  function automatic logic [XW-1:0] absDiff(input logic [XW-1:0] a,
                                            input logic [XW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Count increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] satInc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : (c + CNT_ONE);
  endfunction

  // Coordinate sum with zero-extended addend, sticking at all-ones.
  function automatic logic [SW-1:0] satAdd(input logic [SW-1:0] s,
                                           input logic [XW-1:0] v);
    logic [SW:0] t;
    t = {1'b0, s} + {{(SW+1-XW){1'b0}}, v};
    return t[SW] ? {SW{1'b1}} : t[SW-1:0];
  endfunction

  // ---------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------
  logic            r_s1Valid;
  logic            r_s1Sof;
  logic            r_s1Eof;
  logic [XW-1:0]   r_s1X;
  logic [XW-1:0]   r_s1Y;
  logic [XW-1:0]   r_s1Range;

  // ---------------------------------------------------------------------
  // Working state (current frame accumulation)
  // ---------------------------------------------------------------------
  logic            r_active  [N_CLUSTERS];
  logic [XW-1:0]   r_anchorX [N_CLUSTERS];
  logic [XW-1:0]   r_anchorY [N_CLUSTERS];
  logic [CW-1:0]   r_count   [N_CLUSTERS];
  logic [SW-1:0]   r_sumX    [N_CLUSTERS];
  logic [SW-1:0]   r_sumY    [N_CLUSTERS];
  logic [XW-1:0]   r_minX    [N_CLUSTERS];
  logic [XW-1:0]   r_maxX    [N_CLUSTERS];
  logic [XW-1:0]   r_minY    [N_CLUSTERS];
  logic [XW-1:0]   r_maxY    [N_CLUSTERS];
  logic [CW-1:0]   r_dropped;

  // Next working state computed from the stage-1 pixel
  logic            w_active  [N_CLUSTERS];
  logic [XW-1:0]   w_anchorX [N_CLUSTERS];
  logic [XW-1:0]   w_anchorY [N_CLUSTERS];
  logic [CW-1:0]   w_count   [N_CLUSTERS];
  logic [SW-1:0]   w_sumX    [N_CLUSTERS];
  logic [SW-1:0]   w_sumY    [N_CLUSTERS];
  logic [XW-1:0]   w_minX    [N_CLUSTERS];
  logic [XW-1:0]   w_maxX    [N_CLUSTERS];
  logic [XW-1:0]   w_minY    [N_CLUSTERS];
  logic [XW-1:0]   w_maxY    [N_CLUSTERS];
  logic [CW-1:0]   w_dropped;

  // Slot selection
  logic [N_CLUSTERS-1:0] w_match;
  logic [N_CLUSTERS-1:0] w_matchSel;
  logic [N_CLUSTERS-1:0] w_freeSel;
  logic                  w_matchFound;
  logic                  w_freeFound;

  // ---------------------------------------------------------------------
  // Published result bank
  // ---------------------------------------------------------------------
  logic [CW*N_CLUSTERS-1:0] r_resCount;
  logic [SW*N_CLUSTERS-1:0] r_resSumX;
  logic [SW*N_CLUSTERS-1:0] r_resSumY;
  logic [XW*N_CLUSTERS-1:0] r_resMinX;
  logic [XW*N_CLUSTERS-1:0] r_resMaxX;
  logic [XW*N_CLUSTERS-1:0] r_resMinY;
  logic [XW*N_CLUSTERS-1:0] r_resMaxY;
  logic [CW-1:0]            r_resDropped;
  logic                     r_resValid;
  logic [CW-1:0]            r_frameCount;

  logic                     w_publish;

  assign w_publish = r_s1Valid && r_s1Eof;

  // Stage 1: capture the incoming pixel and its frame markers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1Valid <= 1'b0;
      r_s1Sof   <= 1'b0;
      r_s1Eof   <= 1'b0;
      r_s1X     <= '0;
      r_s1Y     <= '0;
      r_s1Range <= '0;
    end else begin
      r_s1Valid <= valid;
      r_s1Sof   <= sof;
      r_s1Eof   <= eof;
      r_s1X     <= X;
      r_s1Y     <= Y;
      r_s1Range <= range;
    end
  end

  // Stage 2 next state: optional frame clear, then match / allocate / drop.
  always_comb begin
    w_active     = r_active;
    w_anchorX    = r_anchorX;
    w_anchorY    = r_anchorY;
    w_count      = r_count;
    w_sumX       = r_sumX;
    w_sumY       = r_sumY;
    w_minX       = r_minX;
    w_maxX       = r_maxX;
    w_minY       = r_minY;
    w_maxY       = r_maxY;
    w_dropped    = r_dropped;
    w_match      = '0;
    w_matchSel   = '0;
    w_freeSel    = '0;
    w_matchFound = 1'b0;
    w_freeFound  = 1'b0;

    if (r_s1Valid) begin
      // A start-of-frame pixel wipes the previous frame before it is applied.
      if (r_s1Sof) begin
        for (int k = 0; k < N_CLUSTERS; k++) begin
          w_active[k]  = 1'b0;
          w_anchorX[k] = '0;
          w_anchorY[k] = '0;
          w_count[k]   = '0;
          w_sumX[k]    = '0;
          w_sumY[k]    = '0;
          w_minX[k]    = '0;
          w_maxX[k]    = '0;
          w_minY[k]    = '0;
          w_maxY[k]    = '0;
        end
        w_dropped = '0;
      end

      // Lowest-index matching slot and lowest-index free slot.
      for (int k = 0; k < N_CLUSTERS; k++) begin
        w_match[k] = w_active[k] &&
                     (absDiff(r_s1X, w_anchorX[k]) <= r_s1Range) &&
                     (absDiff(r_s1Y, w_anchorY[k]) <= r_s1Range);
        w_matchSel[k] = w_match[k] && !w_matchFound;
        if (w_match[k]) begin
          w_matchFound = 1'b1;
        end
        w_freeSel[k] = !w_active[k] && !w_freeFound;
        if (!w_active[k]) begin
          w_freeFound = 1'b1;
        end
      end

      for (int k = 0; k < N_CLUSTERS; k++) begin
        if (w_matchSel[k]) begin
          w_count[k] = satInc(w_count[k]);
          w_sumX[k]  = satAdd(w_sumX[k], r_s1X);
          w_sumY[k]  = satAdd(w_sumY[k], r_s1Y);
          if (r_s1X < w_minX[k]) w_minX[k] = r_s1X;
          if (r_s1X > w_maxX[k]) w_maxX[k] = r_s1X;
          if (r_s1Y < w_minY[k]) w_minY[k] = r_s1Y;
          if (r_s1Y > w_maxY[k]) w_maxY[k] = r_s1Y;
        end else if (!w_matchFound && w_freeSel[k]) begin
          w_active[k]  = 1'b1;
          w_anchorX[k] = r_s1X;
          w_anchorY[k] = r_s1Y;
          w_count[k]   = CNT_ONE;
          w_sumX[k]    = {{(SW-XW){1'b0}}, r_s1X};
          w_sumY[k]    = {{(SW-XW){1'b0}}, r_s1Y};
          w_minX[k]    = r_s1X;
          w_maxX[k]    = r_s1X;
          w_minY[k]    = r_s1Y;
          w_maxY[k]    = r_s1Y;
        end
      end

      if (!w_matchFound && !w_freeFound) begin
        w_dropped = satInc(w_dropped);
      end
    end
  end

  // Stage 2 register: commit the working state every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_CLUSTERS; k++) begin
        r_active[k]  <= 1'b0;
        r_anchorX[k] <= '0;
        r_anchorY[k] <= '0;
        r_count[k]   <= '0;
        r_sumX[k]    <= '0;
        r_sumY[k]    <= '0;
        r_minX[k]    <= '0;
        r_maxX[k]    <= '0;
        r_minY[k]    <= '0;
        r_maxY[k]    <= '0;
      end
      r_dropped <= '0;
    end else begin
      r_active  <= w_active;
      r_anchorX <= w_anchorX;
      r_anchorY <= w_anchorY;
      r_count   <= w_count;
      r_sumX    <= w_sumX;
      r_sumY    <= w_sumY;
      r_minX    <= w_minX;
      r_maxX    <= w_maxX;
      r_minY    <= w_minY;
      r_maxY    <= w_maxY;
      r_dropped <= w_dropped;
    end
  end

  // Publish the post-update working state on an end-of-frame pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resCount   <= '0;
      r_resSumX    <= '0;
      r_resSumY    <= '0;
      r_resMinX    <= '0;
      r_resMaxX    <= '0;
      r_resMinY    <= '0;
      r_resMaxY    <= '0;
      r_resDropped <= '0;
      r_resValid   <= 1'b0;
      r_frameCount <= '0;
    end else begin
      r_resValid <= w_publish;
      if (w_publish) begin
        for (int k = 0; k < N_CLUSTERS; k++) begin
          r_resCount[k*CW +: CW] <= w_active[k] ? w_count[k] : '0;
          r_resSumX[k*SW +: SW]  <= w_active[k] ? w_sumX[k]  : '0;
          r_resSumY[k*SW +: SW]  <= w_active[k] ? w_sumY[k]  : '0;
          r_resMinX[k*XW +: XW]  <= w_active[k] ? w_minX[k]  : '0;
          r_resMaxX[k*XW +: XW]  <= w_active[k] ? w_maxX[k]  : '0;
          r_resMinY[k*XW +: XW]  <= w_active[k] ? w_minY[k]  : '0;
          r_resMaxY[k*XW +: XW]  <= w_active[k] ? w_maxY[k]  : '0;
        end
        r_resDropped <= w_dropped;
        r_frameCount <= r_frameCount + CNT_ONE;
      end
    end
  end

  assign res_count   = r_resCount;
  assign res_sum_x   = r_resSumX;
  assign res_sum_y   = r_resSumY;
  assign res_min_x   = r_resMinX;
  assign res_max_x   = r_resMaxX;
  assign res_min_y   = r_resMinY;
  assign res_max_y   = r_resMaxY;
  assign res_dropped = r_resDropped;
  assign res_valid   = r_resValid;
  assign frame_count = r_frameCount;

endmodule

// File: tb/tb_pixel_cluster_frame_tracker.sv
// tb_pixel_cluster_frame_tracker
// Directed frames with hand-computed published banks, plus short sequences
// for bank hold, mid-frame reset and counter saturation (second instance
// with a 4-bit counter).

module tb_pixel_cluster_frame_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic        sof;
  logic        eof;
  logic [15:0] X;
  logic [15:0] Y;
  logic [15:0] rangeIn;

  logic [63:0]  resCount;
  logic [127:0] resSumX;
  logic [127:0] resSumY;
  logic [63:0]  resMinX;
  logic [63:0]  resMaxX;
  logic [63:0]  resMinY;
  logic [63:0]  resMaxY;
  logic [15:0]  resDropped;
  logic         resValid;
  logic [15:0]  frameCount;

  logic [15:0]  resCount4;
  logic [127:0] resSumX4;
  logic [127:0] resSumY4;
  logic [63:0]  resMinX4;
  logic [63:0]  resMaxX4;
  logic [63:0]  resMinY4;
  logic [63:0]  resMaxY4;
  logic [3:0]   resDropped4;
  logic         resValid4;
  logic [3:0]   frameCount4;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] rng;
    logic        sof;
    logic        eof;
    logic [63:0] expCounts;
    logic [15:0] expDropped;
    logic [15:0] expFrames;
    logic [31:0] expSumX;
    logic [31:0] expSumY;
    logic [15:0] expMinX;
    logic [15:0] expMaxX;
    logic [15:0] expMinY;
    logic [15:0] expMaxY;
    logic [47:0] expMaxXHi;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pixel_cluster_frame_tracker dut (
    .clk(clk), .reset(reset), .X(X), .Y(Y), .valid(valid), .sof(sof),
    .eof(eof), .range(rangeIn), .res_count(resCount), .res_sum_x(resSumX),
    .res_sum_y(resSumY), .res_min_x(resMinX), .res_max_x(resMaxX),
    .res_min_y(resMinY), .res_max_y(resMaxY), .res_dropped(resDropped),
    .res_valid(resValid), .frame_count(frameCount)
  );

  pixel_cluster_frame_tracker #(.COUNTER_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .X(X), .Y(Y), .valid(valid), .sof(sof),
    .eof(eof), .range(rangeIn), .res_count(resCount4), .res_sum_x(resSumX4),
    .res_sum_y(resSumY4), .res_min_x(resMinX4), .res_max_x(resMaxX4),
    .res_min_y(resMinY4), .res_max_y(resMaxY4), .res_dropped(resDropped4),
    .res_valid(resValid4), .frame_count(frameCount4)
  );

  function automatic vec_t pix(input int x, input int y, input int rng,
                               input bit s);
    vec_t v;
    v.x = x[15:0]; v.y = y[15:0]; v.rng = rng[15:0];
    v.sof = s; v.eof = 1'b0;
    v.expCounts = '0; v.expDropped = '0; v.expFrames = '0;
    v.expSumX = '0; v.expSumY = '0;
    v.expMinX = '0; v.expMaxX = '0; v.expMinY = '0; v.expMaxY = '0;
    v.expMaxXHi = '0;
    return v;
  endfunction

  function automatic vec_t endPix(input int x, input int y, input int rng,
                                  input bit s, input logic [63:0] cnts,
                                  input int drop, input int frames,
                                  input int sx, input int sy,
                                  input int mnx, input int mxx,
                                  input int mny, input int mxy,
                                  input logic [47:0] hi);
    vec_t v;
    v = pix(x, y, rng, s);
    v.eof = 1'b1;
    v.expCounts = cnts;
    v.expDropped = drop[15:0]; v.expFrames = frames[15:0];
    v.expSumX = sx; v.expSumY = sy;
    v.expMinX = mnx[15:0]; v.expMaxX = mxx[15:0];
    v.expMinY = mny[15:0]; v.expMaxY = mxy[15:0];
    v.expMaxXHi = hi;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [127:0] act,
                          input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare the published bank against a record's expectations.
  task automatic checkOutput(input vec_t v, input int fr);
    checkVal($sformatf("f%0d_valid", fr),   128'(resValid),     128'(1'b1));
    checkVal($sformatf("f%0d_counts", fr),  128'(resCount),     128'(v.expCounts));
    checkVal($sformatf("f%0d_dropped", fr), 128'(resDropped),   128'(v.expDropped));
    checkVal($sformatf("f%0d_frames", fr),  128'(frameCount),   128'(v.expFrames));
    checkVal($sformatf("f%0d_sumx0", fr),   128'(resSumX[31:0]), 128'(v.expSumX));
    checkVal($sformatf("f%0d_sumy0", fr),   128'(resSumY[31:0]), 128'(v.expSumY));
    checkVal($sformatf("f%0d_minx0", fr),   128'(resMinX[15:0]), 128'(v.expMinX));
    checkVal($sformatf("f%0d_maxx0", fr),   128'(resMaxX[15:0]), 128'(v.expMaxX));
    checkVal($sformatf("f%0d_miny0", fr),   128'(resMinY[15:0]), 128'(v.expMinY));
    checkVal($sformatf("f%0d_maxy0", fr),   128'(resMaxY[15:0]), 128'(v.expMaxY));
    checkVal($sformatf("f%0d_maxxhi", fr),  128'(resMaxX[63:16]), 128'(v.expMaxXHi));
  endtask

  // Drive one pixel; on eof idle the input and check the publish timing.
  task automatic applyStimulus(input vec_t v, input int fr);
    @(negedge clk);
    X = v.x; Y = v.y; rangeIn = v.rng; sof = v.sof; eof = v.eof;
    valid = 1'b1;
    if (v.eof) begin
      @(negedge clk);
      valid = 1'b0; sof = 1'b0; eof = 1'b0;
      checkVal($sformatf("f%0d_early_valid", fr), 128'(resValid), 128'(1'b0));
      @(posedge clk); #1;
      checkOutput(v, fr);
      @(posedge clk); #1;
      checkVal($sformatf("f%0d_pulse_end", fr), 128'(resValid), 128'(1'b0));
    end
  endtask

  task automatic idleInput();
    @(negedge clk);
    valid = 1'b0; sof = 1'b0; eof = 1'b0;
  endtask

  initial begin
    int fr;
    reset = 1'b1; valid = 1'b0; sof = 1'b0; eof = 1'b0;
    X = '0; Y = '0; rangeIn = '0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_counts",  128'(resCount),   128'(0));
    checkVal("rst_sumx",    resSumX,          128'(0));
    checkVal("rst_minx",    128'(resMinX),    128'(0));
    checkVal("rst_dropped", 128'(resDropped), 128'(0));
    checkVal("rst_valid",   128'(resValid),   128'(0));
    checkVal("rst_frames",  128'(frameCount), 128'(0));
    @(negedge clk);
    reset = 1'b0;

    // Frame 1: basic clustering
    vecs.push_back(pix(100, 100, 50, 1));
    vecs.push_back(pix(125, 125, 50, 0));
    vecs.push_back(endPix(75, 100, 50, 0, 64'h3, 0, 1, 300, 325,
                          75, 125, 100, 125, 48'h0));
    // Frame 2: allocation and lowest-index priority
    vecs.push_back(pix(10, 10, 50, 1));
    vecs.push_back(pix(20, 20, 50, 0));
    vecs.push_back(pix(200, 200, 50, 0));
    vecs.push_back(pix(300, 200, 50, 0));
    vecs.push_back(pix(100, 200, 50, 0));
    vecs.push_back(endPix(40, 40, 50, 0, 64'h0001_0001_0001_0003, 0, 2,
                          70, 70, 10, 40, 10, 40,
                          {16'd100, 16'd300, 16'd200}));
    // Frame 3: overflow drops
    vecs.push_back(pix(1, 1, 0, 1));
    vecs.push_back(pix(2, 2, 0, 0));
    vecs.push_back(pix(3, 3, 0, 0));
    vecs.push_back(pix(4, 4, 0, 0));
    vecs.push_back(pix(5, 5, 0, 0));
    vecs.push_back(endPix(6, 6, 0, 0, 64'h0001_0001_0001_0001, 2, 3,
                          1, 1, 1, 1, 1, 1, {16'd4, 16'd3, 16'd2}));
    // Frame 4: restart clears slots and drop count
    vecs.push_back(endPix(500, 500, 0, 1, 64'h1, 0, 4, 500, 500,
                          500, 500, 500, 500, 48'h0));
    // Frame 5: single-pixel frame
    vecs.push_back(endPix(7, 9, 0, 1, 64'h1, 0, 5, 7, 9, 7, 7, 9, 9, 48'h0));
    // Frame 6: no sof, accumulates onto frame 5; range edge match/miss
    vecs.push_back(pix(8, 9, 1, 0));
    vecs.push_back(pix(9, 9, 1, 0));
    vecs.push_back(endPix(7, 10, 1, 0, 64'h0000_0000_0001_0003, 0, 6,
                          22, 28, 7, 8, 9, 10, 48'h9));

    fr = 1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], fr);
      if (vecs[i].eof) fr++;
    end

    // Bank holds while a new frame accumulates without eof
    applyStimulus(pix(1000, 1000, 0, 1), 0);
    applyStimulus(pix(2000, 2000, 0, 0), 0);
    idleInput();
    repeat (3) @(posedge clk);
    #1;
    checkVal("hold_counts", 128'(resCount), 128'(64'h0000_0000_0001_0003));
    checkVal("hold_sumx0",  128'(resSumX[31:0]), 128'(22));
    checkVal("hold_frames", 128'(frameCount), 128'(6));
    checkVal("hold_valid",  128'(resValid),   128'(0));

    // Reset mid-frame with a pixel pending in stage 1
    applyStimulus(pix(1, 1, 0, 1), 0);
    applyStimulus(pix(2, 2, 0, 0), 0);
    @(negedge clk);
    valid = 1'b0; sof = 1'b0; eof = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkVal("midrst_counts", 128'(resCount),   128'(0));
    checkVal("midrst_frames", 128'(frameCount), 128'(0));
    checkVal("midrst_valid",  128'(resValid),   128'(0));
    applyStimulus(endPix(5, 5, 0, 0, 64'h1, 0, 1, 5, 5, 5, 5, 5, 5, 48'h0), 7);

    // Saturation: 20 matching pixels, 4-bit counter instance sticks at 15
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(pix(50, 1, 10, 1), 0);
    for (int i = 0; i < 18; i++) begin
      applyStimulus(pix(50, 1, 10, 0), 0);
    end
    applyStimulus(endPix(50, 1, 10, 0, 64'h14, 0, 1, 1000, 20,
                         50, 50, 1, 1, 48'h0), 8);
    checkVal("sat_count4",  128'(resCount4[3:0]), 128'(15));
    checkVal("sat_sumx4",   128'(resSumX4[31:0]), 128'(1000));
    checkVal("sat_frames4", 128'(frameCount4),    128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case stimulus ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
